// File: rtl/instr_mem_pipe_if.sv
// Fetch/response and program-load signal bundle for instr_mem_pipe.
// Latency: none (wires only).
// Backpressure: req_ready / rsp_ready travel against their valids.
interface instr_mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_oob;
    logic              rsp_perr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // fetch unit / program loader side
    modport master (
        output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_data, rsp_oob, rsp_perr
    );

    // memory side
    modport slave (
        input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_data, rsp_oob, rsp_perr
    );
endinterface

// File: rtl/instr_mem_pipe.sv
// Instruction memory: valid/ready fetch port, read pipeline, response buffer, load port.
// Latency: LAT cycles from accept to rsp_valid (empty buffer), 1 word/cycle sustained.
// Backpressure: credit counter over pipeline+buffer drops req_ready when BUF_D are owed.
// Optional parity storage/check enabled by defining INSTR_MEM_PARITY_EN.
module instr_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536,
    parameter int LAT    = 1,
    parameter int BUF_D  = 4
) (
    input  logic          clock,
    input  logic          resetn,
    instr_mem_pipe_if.slave bus
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(BUF_D);
    localparam int CW = $clog2(BUF_D + 1);
`ifdef INSTR_MEM_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [CW-1:0]   BUF_C   = CW'(BUF_D);

    logic [RAM_W-1:0] mem [DEPTH];

    logic              accept;
    logic              pop;
    logic              rd_oob;
    logic              wr_ok;
    logic [RAM_W-1:0]  rd_word;
    logic [DATA_W-1:0] s0_dat;
    logic              s0_perr;

    logic              push_vld;
    logic [DATA_W-1:0] push_dat;
    logic              push_oob;
    logic              push_perr;

    logic [DATA_W-1:0] buf_dat [BUF_D];
    logic [BUF_D-1:0]  buf_oob;
    logic [BUF_D-1:0]  buf_perr;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     cnt;

    assign accept = bus.req_valid & bus.req_ready;
    assign pop    = bus.rsp_valid & bus.rsp_ready;

    // Out-of-range addresses never touch the RAM.
    assign rd_oob = ({1'b0, bus.req_addr} >= DEPTH_C);
    assign wr_ok  = bus.wr_en & ({1'b0, bus.wr_addr} < DEPTH_C);

    assign rd_word = mem[bus.req_addr[IW-1:0]];
    assign s0_dat  = rd_oob ? '0 : rd_word[DATA_W-1:0];
`ifdef INSTR_MEM_PARITY_EN
    // Stored word (data + even parity bit) must XOR to zero.
    assign s0_perr = ~rd_oob & (^rd_word);
`else
    assign s0_perr = 1'b0;
`endif

    // Program-load write; the read above sees the pre-write word (read-first).
    always_ff @(posedge clock) begin
        if (wr_ok) begin
`ifdef INSTR_MEM_PARITY_EN
            mem[bus.wr_addr[IW-1:0]] <= {^bus.wr_data, bus.wr_data};
`else
            mem[bus.wr_addr[IW-1:0]] <= bus.wr_data;
`endif
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            // Single-cycle read: the buffer entry is the read register.
            assign push_vld  = accept;
            assign push_dat  = s0_dat;
            assign push_oob  = rd_oob;
            assign push_perr = s0_perr;
        end else begin : g_pipe
            logic [LAT-2:0]    pv;
            logic [DATA_W-1:0] pd [LAT-1];
            logic [LAT-2:0]    po;
            logic [LAT-2:0]    pp;

            // Stage valids: cleared by reset so in-flight fetches are discarded.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    pv <= '0;
                end else begin
                    pv[0] <= accept;
                    for (int i = 1; i < LAT - 1; i++) begin
                        pv[i] <= pv[i-1];
                    end
                end
            end

            // Stage payloads move only with a valid behind them.
            always_ff @(posedge clock) begin
                if (accept) begin
                    pd[0] <= s0_dat;
                    po[0] <= rd_oob;
                    pp[0] <= s0_perr;
                end
                for (int i = 1; i < LAT - 1; i++) begin
                    if (pv[i-1]) begin
                        pd[i] <= pd[i-1];
                        po[i] <= po[i-1];
                        pp[i] <= pp[i-1];
                    end
                end
            end

            assign push_vld  = pv[LAT-2];
            assign push_dat  = pd[LAT-2];
            assign push_oob  = po[LAT-2];
            assign push_perr = pp[LAT-2];
        end
    endgenerate

    // Buffer pointers, buffer occupancy and fetch credits.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            cnt  <= '0;
        end else begin
            if (push_vld) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_vld, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Buffer storage; credits guarantee a free slot for every push.
    always_ff @(posedge clock) begin
        if (push_vld) begin
            buf_dat[wptr]  <= push_dat;
            buf_oob[wptr]  <= push_oob;
            buf_perr[wptr] <= push_perr;
        end
    end

    assign bus.req_ready = (cnt < BUF_C);
    assign bus.rsp_valid = (occ != '0);
    // Head fields forced to zero when empty so reset leaves clean outputs.
    assign bus.rsp_data  = bus.rsp_valid ? buf_dat[rptr]  : '0;
    assign bus.rsp_oob   = bus.rsp_valid ? buf_oob[rptr]  : 1'b0;
    assign bus.rsp_perr  = bus.rsp_valid ? buf_perr[rptr] : 1'b0;

endmodule

// File: tb/tb_instr_mem_pipe.sv
module tb_instr_mem_pipe;

    localparam int BUF_D = 4;
    localparam int MEMW  = 1024;

    typedef struct packed {
        logic [31:0] data;
        logic        oob;
        logic        perr;
    } rsp_t;

    logic clock;
    logic resetn;
    int   checks;
    int   errors;
    int   cyc;

    logic [31:0] ref_mem [MEMW];
    bit          ref_bad [MEMW];
    rsp_t        q [$];

`ifdef INSTR_MEM_PARITY_EN
    localparam bit PAR_EXP = 1'b1;
`else
    localparam bit PAR_EXP = 1'b0;
`endif

    instr_mem_pipe_if #(.DATA_W(32), .ADDR_W(16)) bus ();

    instr_mem_pipe #(
        .DATA_W(32), .ADDR_W(16), .DEPTH(MEMW), .LAT(2), .BUF_D(BUF_D)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic rsp_t model_read(logic [15:0] a);
        rsp_t r;
        r = '0;
        if (a >= 16'(MEMW)) begin
            r.oob = 1'b1;
        end else begin
            r.data = ref_mem[a[9:0]];
            if (PAR_EXP) r.perr = ref_bad[a[9:0]];
        end
        return r;
    endfunction

    // One clock: sample at negedge, update reference model, advance past posedge.
    task automatic step(output bit acc, output bit pop, output bit unf, output bit vld,
                        output bit rdy, output bit exp_rdy, output rsp_t got, output rsp_t exp);
        @(negedge clock);
        rdy     = bus.req_ready;
        exp_rdy = (q.size() < BUF_D);
        vld     = bus.rsp_valid;
        acc     = bus.req_valid && bus.req_ready;
        pop     = bus.rsp_valid && bus.rsp_ready;
        got     = '{data: bus.rsp_data, oob: bus.rsp_oob, perr: bus.rsp_perr};
        exp     = '0;
        unf     = 1'b0;
        if (pop) begin
            if (q.size() == 0) unf = 1'b1;
            else exp = q.pop_front();
        end
        if (acc) q.push_back(model_read(bus.req_addr));
        if (bus.wr_en && bus.wr_addr < 16'(MEMW)) begin
            ref_mem[bus.wr_addr[9:0]] = bus.wr_data;
            ref_bad[bus.wr_addr[9:0]] = 1'b0;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req_valid = 1'b1;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
        checks++; if (bus.rsp_oob !== 1'b0) begin errors++; $display("FAIL reset_rsp_oob got %b want 0", bus.rsp_oob); end
        checks++; if (bus.rsp_perr !== 1'b0) begin errors++; $display("FAIL reset_rsp_perr got %b want 0", bus.rsp_perr); end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic load_all();
        bit acc, pop, unf, vld, rdy, erdy;
        rsp_t got, exp;
        bus.wr_en = 1'b1;
        for (int i = 0; i < MEMW; i++) begin
            bus.wr_addr = 16'(i);
            bus.wr_data = $urandom;
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_stream();
        bit acc, pop, unf, vld, rdy, erdy;
        rsp_t got, exp;
        int nacc, npop, c, first_acc;
        int pop_cyc [4];
        bus.wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_addr = 16'h0010 + 16'(i);
            bus.wr_data = 32'hA000_0010 + 32'(i);
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
        end
        bus.wr_en = 1'b0;
        bus.rsp_ready = 1'b1;
        nacc = 0; npop = 0; first_acc = -100;
        for (int k = 0; k < 12; k++) begin
            bus.req_valid = (nacc < 4);
            bus.req_addr  = 16'h0010 + 16'(nacc);
            c = cyc;
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            if (acc) begin
                if (nacc == 0) first_acc = c;
                nacc++;
            end
            if (pop) begin
                checks++;
                if (unf || got !== exp || (npop < 4 && got.data !== 32'hA000_0010 + 32'(npop))) begin
                    errors++;
                    $display("FAIL stream_rsp%0d got %h want %h", npop, got.data, 32'hA000_0010 + 32'(npop));
                end
                if (npop < 4) pop_cyc[npop] = c;
                npop++;
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (npop != 4) begin errors++; $display("FAIL stream_count got %0d want 4", npop); end
        checks++; if (pop_cyc[0] != first_acc + 2) begin errors++; $display("FAIL stream_latency got %0d want %0d", pop_cyc[0] - first_acc, 2); end
        checks++; if (pop_cyc[3] != pop_cyc[0] + 3) begin errors++; $display("FAIL stream_b2b got span %0d want 3", pop_cyc[3] - pop_cyc[0]); end
    endtask

    task automatic test_backpressure();
        bit acc, pop, unf, vld, rdy, erdy, have_head, prev_first;
        rsp_t got, exp, head;
        int nacc, npop;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        nacc = 0; have_head = 1'b0; head = '0; rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.req_addr = 16'($urandom_range(0, MEMW - 1));
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            checks++; if (rdy !== erdy) begin errors++; $display("FAIL bp_ready got %b want %b", rdy, erdy); end
            if (acc) nacc++;
            if (vld) begin
                if (have_head) begin
                    checks++;
                    if (got !== head) begin errors++; $display("FAIL bp_stable got %h want %h", got, head); end
                end else begin
                    head = got; have_head = 1'b1;
                end
            end
        end
        checks++; if (nacc != 4) begin errors++; $display("FAIL bp_accepts got %0d want 4", nacc); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", rdy); end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        npop = 0; prev_first = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            if (prev_first) begin
                checks++;
                if (rdy !== 1'b1) begin errors++; $display("FAIL bp_reassert got %b want 1", rdy); end
            end
            prev_first = 1'b0;
            if (pop) begin
                if (npop == 0) prev_first = 1'b1;
                checks++;
                if (unf || got !== exp) begin errors++; $display("FAIL bp_rsp%0d got %h want %h", npop, got, exp); end
                npop++;
            end
        end
        checks++; if (npop != 4) begin errors++; $display("FAIL bp_drain got %0d want 4", npop); end
    endtask

    task automatic test_oob();
        bit acc, pop, unf, vld, rdy, erdy;
        rsp_t got, exp;
        rsp_t r [2];
        int npop;
        logic [15:0] addrs [2];
        addrs[0] = 16'h0400; addrs[1] = 16'h03FF;
        bus.rsp_ready = 1'b1;
        npop = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = (k < 2);
            bus.req_addr  = addrs[k % 2];
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            if (pop) begin
                checks++;
                if (unf || got !== exp) begin errors++; $display("FAIL oob_rsp got %h want %h", got, exp); end
                if (npop < 2) r[npop] = got;
                npop++;
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (npop != 2) begin errors++; $display("FAIL oob_count got %0d want 2", npop); end
        checks++; if (r[0].oob !== 1'b1 || r[0].data !== 32'h0) begin errors++; $display("FAIL oob_hi got %h/%b want 0/1", r[0].data, r[0].oob); end
        checks++; if (r[1].oob !== 1'b0 || r[1].data !== ref_mem[10'h3FF]) begin errors++; $display("FAIL oob_lo got %h/%b want %h/0", r[1].data, r[1].oob, ref_mem[10'h3FF]); end
    endtask

    task automatic test_collision();
        bit acc, pop, unf, vld, rdy, erdy;
        rsp_t got, exp;
        rsp_t r [2];
        int npop;
        bus.rsp_ready = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 16'h0020; bus.wr_data = 32'h1234_5678;
        step(acc, pop, unf, vld, rdy, erdy, got, exp);
        bus.wr_data = 32'hDEAD_BEEF; bus.req_valid = 1'b1; bus.req_addr = 16'h0020;
        npop = 0;
        for (int k = 0; k < 8; k++) begin
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            bus.wr_en = 1'b0;
            bus.req_valid = (k == 0);
            if (pop) begin
                checks++;
                if (unf || got !== exp) begin errors++; $display("FAIL rw_rsp got %h want %h", got, exp); end
                if (npop < 2) r[npop] = got;
                npop++;
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (npop != 2) begin errors++; $display("FAIL rw_count got %0d want 2", npop); end
        checks++; if (r[0].data !== 32'h1234_5678) begin errors++; $display("FAIL rw_old got %h want 12345678", r[0].data); end
        checks++; if (r[1].data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_new got %h want deadbeef", r[1].data); end
    endtask

    task automatic test_parity();
        bit acc, pop, unf, vld, rdy, erdy;
        rsp_t got, exp;
        rsp_t r [2];
        int npop;
        bus.rsp_ready = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_addr = 16'h0030; bus.wr_data = 32'h0F0F_0F0F;
        step(acc, pop, unf, vld, rdy, erdy, got, exp);
        bus.wr_addr = 16'h0031; bus.wr_data = 32'h1122_3344;
        step(acc, pop, unf, vld, rdy, erdy, got, exp);
        bus.wr_en = 1'b0;
        dut.mem[10'h030][5] = ~dut.mem[10'h030][5];
        ref_mem[10'h030] = ref_mem[10'h030] ^ 32'h0000_0020;
        ref_bad[10'h030] = 1'b1;
        npop = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = (k < 2);
            bus.req_addr  = 16'h0030 + 16'(k % 2);
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            if (pop) begin
                checks++;
                if (unf || got !== exp) begin errors++; $display("FAIL par_rsp got %h want %h", got, exp); end
                if (npop < 2) r[npop] = got;
                npop++;
            end
        end
        bus.req_valid = 1'b0;
        checks++; if (npop != 2) begin errors++; $display("FAIL par_count got %0d want 2", npop); end
        checks++; if (r[0].perr !== PAR_EXP || r[0].data !== 32'h0F0F_0F2F) begin errors++; $display("FAIL par_bad got %h/%b want 0f0f0f2f/%b", r[0].data, r[0].perr, PAR_EXP); end
        checks++; if (r[1].perr !== 1'b0 || r[1].data !== 32'h1122_3344) begin errors++; $display("FAIL par_clean got %h/%b want 11223344/0", r[1].data, r[1].perr); end
    endtask

    task automatic test_reset_inflight();
        bit acc, pop, unf, vld, rdy, erdy;
        rsp_t got, exp;
        int nacc, seen;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        nacc = 0;
        for (int k = 0; k < 3; k++) begin
            bus.req_addr = 16'h0010 + 16'(k);
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            if (acc) nacc++;
        end
        bus.req_valid = 1'b0;
        checks++; if (nacc != 3) begin errors++; $display("FAIL rst_fly_accepts got %0d want 3", nacc); end
        resetn = 1'b0;
        q.delete();
        #2;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_fly_async got v%b r%b want v0 r1", bus.rsp_valid, bus.req_ready); end
        @(posedge clock);
        #1;
        resetn = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            if (vld) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_fly_deliver got %0d want 0", seen); end
    endtask

    task automatic test_random();
        bit acc, pop, unf, vld, rdy, erdy, stalled;
        rsp_t got, exp, prev;
        stalled = 1'b0; prev = '0;
        for (int k = 0; k < 400; k++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_addr  = 16'($urandom_range(0, MEMW + 80));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.wr_en     = ($urandom_range(0, 7) == 0);
            bus.wr_addr   = 16'($urandom_range(0, MEMW + 80));
            bus.wr_data   = $urandom;
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            checks++; if (rdy !== erdy) begin errors++; $display("FAIL rnd_ready got %b want %b", rdy, erdy); end
            if (stalled && vld) begin
                checks++;
                if (got !== prev) begin errors++; $display("FAIL rnd_stable got %h want %h", got, prev); end
            end
            if (pop) begin
                checks++;
                if (unf || got !== exp) begin errors++; $display("FAIL rnd_rsp got %h want %h", got, exp); end
            end
            stalled = vld && !pop;
            prev = got;
        end
        idle_inputs();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(acc, pop, unf, vld, rdy, erdy, got, exp);
            if (pop) begin
                checks++;
                if (unf || got !== exp) begin errors++; $display("FAIL rnd_drain got %h want %h", got, exp); end
            end
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_leftover got %0d want 0", q.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        load_all();
        test_stream();
        test_backpressure();
        test_oob();
        test_collision();
        test_parity();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
